fifo_burst_writer: RTL and testbench
====================================

# fifo_burst_writer

Write-side packet framer that sits in the `wrclk` domain in front of the 16-bit dual-clock FIFO and is the only driver of its write port. It accepts a valid/ready sample stream and groups samples into fixed-length packets of `BURST_LEN` words. Each packet gets a header word (sync marker plus sequence number) and, optionally, a checksum trailer. A packet starts only when the FIFO's write-side fill count guarantees the whole packet fits, so the read side never sees a truncated packet.

## Interface
- `WIDTH`, 16: data width; must equal the FIFO width, minimum 9.
- `ADDR_W`, 11: FIFO address width; usable capacity is `2**ADDR_W - 1` words.
- `BURST_LEN`, 64: payload words per packet, from 1 to `2**ADDR_W - 8`.
- `SYNC`, 8'hA5: header marker, `WIDTH-8` bits.

Ports:
- `wrclk`  in  1  FIFO write clock; all logic is rising-edge.
- `aclr`  in  1  reset, asynchronous, active-low.
- `en`  in  1  allows a new packet to start; sampled in IDLE only.
- `s_valid`  in  1  upstream word valid.
- `s_data`  in  WIDTH  upstream word.
- `s_ready`  out  1  combinational: `state==PAY && !wrfull`.
- `wrfull`  in  1  from the FIFO write side.
- `wrusedw`  in  ADDR_W  from the FIFO write side; this count lags by up to 2 words.
- `wrreq`  out  1  registered FIFO write enable.
- `data`  out  WIDTH  registered FIFO write data.
- `busy`  out  1  registered; 1 while `state != IDLE`.
- `pkt_seq`  out  8  registered sequence number of the next header.
- `ovf_err`  out  1  sticky; set when `wrfull` is seen while in PAY or TRL.

## Operation
- `PKT` = `BURST_LEN+1` words, or `BURST_LEN+2` when the checksum trailer is enabled.
- States are IDLE, PAY, and TRL.
- **Room test:** `room = ({1'b0,wrusedw} + PKT + 2) <= 2**ADDR_W - 1`, evaluated at ADDR_W+1 bits or wider. The +2 covers the `wrusedw` lag.
- **IDLE → PAY** when `en && s_valid && room && !wrfull`. On that edge:
  - `wrreq`<=1 and `data`<={SYNC, pkt_seq}.
  - The word counter and checksum clear to 0.
  - `s_valid` is not consumed on this edge.
- **In PAY:**
  - On each edge with `s_valid && s_ready`: `wrreq`<=1, `data`<=`s_data`, checksum += `s_data` (mod 2**WIDTH), counter++.
  - On the `BURST_LEN`-th accepted word, go to TRL (checksum enabled) or IDLE (disabled).
  - `pkt_seq` increments, wrapping 255→0, at packet completion.
- **In TRL**, if `!wrfull`: `wrreq`<=1 and `data`<=final checksum, then go to IDLE. If `wrfull` is high, stall in TRL.
- `wrreq`<=0 on every edge not listed above.
- `data` holds its last value when `wrreq`=0.
- **`wrfull` during PAY/TRL:** set `ovf_err`, stall with `s_ready`=0, and write nothing until `wrfull` falls. No word is dropped.
- `ovf_err` is cleared only by `aclr`.
- Upstream back-pressure (`s_valid`=0) mid-packet stalls in PAY indefinitely.
- Deasserting `en` mid-packet has no effect; the packet completes.

## Timing
- **Reset values:**
  - State = IDLE.
  - `wrreq`, `data`, `busy`, `pkt_seq`, `ovf_err`, and the checksum are all 0.
  - `s_ready`=0.
- **Reset mid-packet:** aborts immediately; the partial packet remains in the FIFO, and the reader resynchronises on `SYNC`.
- **Latency:**
  - Header `wrreq` is high in the cycle after the IDLE→PAY edge.
  - Each accepted payload word appears on `data`/`wrreq` one cycle after acceptance.
- **Throughput:** minimum packet is `PKT`+1 cycles. IDLE always lasts at least 1 cycle between packets. Gapless `s_valid` gives one word per cycle inside a packet.
- `busy` rises on the IDLE→PAY edge and falls on the edge that returns to IDLE.

## Configuration
- `BURST_WR_CSUM_EN` defined:
  - TRL state present.
  - `PKT = BURST_LEN+2`.
  - The trailer word is the mod-2**WIDTH sum of the payload words.
- `BURST_WR_CSUM_EN` undefined:
  - No TRL state and no checksum register.
  - `PKT = BURST_LEN+1`.
  - PAY goes directly to IDLE after the last word.

## Test plan
- **Single packet:** BURST_LEN=4, `s_data`=1,2,3,4 gapless, `wrusedw`=0 → `wrreq` words A500,0001,0002,0003,0004. With the checksum enabled, a further word 000A follows. `pkt_seq` becomes 1.
- **Room gating:** ADDR_W=4, BURST_LEN=4, checksum enabled (PKT=6), `wrusedw`=8 → no start, since 8+6+2=16 > 15. `wrusedw`=7 → start on the next edge.
- **Sequence wrap:** run 257 packets → header low bytes run 00..FF, then 00.
- **Back-pressure:** insert `s_valid` gaps and force `wrfull`=1 for 3 cycles mid-PAY → `s_ready`=0 for those cycles and `ovf_err`=1. All payload words arrive in order with none lost or duplicated.
- **Async reset mid-packet:** pulse `aclr` low after 2 payload words → `wrreq`=0, state IDLE, `pkt_seq`=0 immediately. The next packet header is A500.

Source files
------------

// File: rtl/fifo_burst_writer.sv
// fifo_burst_writer: write-side packet framer for the 16-bit dual-clock FIFO.
// Groups a valid/ready sample stream into BURST_LEN-word packets, each led by
// a {SYNC, seq} header word. A packet only starts when the FIFO fill count
// guarantees the whole packet fits.
// Optional feature macro: BURST_WR_CSUM_EN appends a mod-2**WIDTH checksum
// trailer word to every packet.
module fifo_burst_writer #(
  parameter int               WIDTH     = 16,
  parameter int               ADDR_W    = 11,
  parameter int               BURST_LEN = 64,
  parameter logic [WIDTH-9:0] SYNC      = (WIDTH-8)'(8'hA5)
) (
  input  logic              wrclk,
  input  logic              aclr,
  input  logic              en,
  input  logic              s_valid,
  input  logic [WIDTH-1:0]  s_data,
  output logic              s_ready,
  input  logic              wrfull,
  input  logic [ADDR_W-1:0] wrusedw,
  output logic              wrreq,
  output logic [WIDTH-1:0]  data,
  output logic              busy,
  output logic [7:0]        pkt_seq,
  output logic              ovf_err
);

`ifdef BURST_WR_CSUM_EN
  localparam int PKT = BURST_LEN + 2;
`else
  localparam int PKT = BURST_LEN + 1;
`endif
  localparam int CAP   = (1 << ADDR_W) - 1;
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam int RW    = ADDR_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    PAY
`ifdef BURST_WR_CSUM_EN
    , TRL
`endif
  } state_t;

  state_t             state_q, state_d;
  logic               wrreq_q, wrreq_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               busy_q, busy_d;
  logic [7:0]         seq_q, seq_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef BURST_WR_CSUM_EN
  logic [WIDTH-1:0]   csum_q, csum_d;
`endif

  // The +2 margin absorbs the lag of wrusedw behind the real fill level;
  // the sum is kept two bits wider than the count so it cannot overflow.
  logic [RW-1:0] room_sum;
  logic          room;
  assign room_sum = {2'b00, wrusedw} + RW'(PKT + 2);
  assign room     = (room_sum <= RW'(CAP));

  assign s_ready = (state_q == PAY) && !wrfull;
  assign wrreq   = wrreq_q;
  assign data    = data_q;
  assign busy    = busy_q;
  assign pkt_seq = seq_q;
  assign ovf_err = ovf_q;

  // Next-state and registered-output logic for the framer FSM.
  always_comb begin
    state_d = state_q;
    wrreq_d = 1'b0;
    data_d  = data_q;
    seq_d   = seq_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
`ifdef BURST_WR_CSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE: begin
        // Header goes out on the start edge; the pending sample waits for PAY.
        if (en && s_valid && room && !wrfull) begin
          state_d = PAY;
          wrreq_d = 1'b1;
          data_d  = {SYNC, seq_q};
          cnt_d   = '0;
`ifdef BURST_WR_CSUM_EN
          csum_d  = '0;
`endif
        end
      end
      PAY: begin
        if (wrfull) begin
          ovf_d = 1'b1;
        end else if (s_valid) begin
          wrreq_d = 1'b1;
          data_d  = s_data;
          cnt_d   = cnt_q + 1'b1;
`ifdef BURST_WR_CSUM_EN
          csum_d  = csum_q + s_data;
          if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
            state_d = TRL;
          end
`else
          if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
            state_d = IDLE;
            seq_d   = seq_q + 8'd1;
          end
`endif
        end
      end
`ifdef BURST_WR_CSUM_EN
      TRL: begin
        if (wrfull) begin
          ovf_d = 1'b1;
        end else begin
          wrreq_d = 1'b1;
          data_d  = csum_q;
          state_d = IDLE;
          seq_d   = seq_q + 8'd1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any packet in flight.
  always_ff @(posedge wrclk or negedge aclr) begin
    if (!aclr) begin
      state_q <= IDLE;
      wrreq_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      seq_q   <= 8'd0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef BURST_WR_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      wrreq_q <= wrreq_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      seq_q   <= seq_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
`ifdef BURST_WR_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Testbench for fifo_burst_writer: scoreboard of expected FIFO writes fed by a
// packet-level reference model, checked by an independent monitor.
module tb_fifo_burst_writer;
  localparam int WIDTH     = 16;
  localparam int ADDR_W    = 4;
  localparam int BURST_LEN = 4;
`ifdef BURST_WR_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  localparam int PKT   = BURST_LEN + 1 + (CSUM ? 1 : 0);
  localparam int CAP   = (1 << ADDR_W) - 1;
  localparam int LIMIT = CAP - PKT - 2;  // largest wrusedw that still allows a start

  logic              wrclk = 1'b0;
  logic              aclr = 1'b0;
  logic              en = 1'b0;
  logic              s_valid = 1'b0;
  logic [WIDTH-1:0]  s_data = '0;
  logic              s_ready;
  logic              wrfull = 1'b0;
  logic [ADDR_W-1:0] wrusedw = '0;
  logic              wrreq;
  logic [WIDTH-1:0]  data;
  logic              busy;
  logic [7:0]        pkt_seq;
  logic              ovf_err;

  fifo_burst_writer #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .SYNC(8'hA5)
  ) dut (
    .wrclk(wrclk), .aclr(aclr), .en(en), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .wrfull(wrfull), .wrusedw(wrusedw), .wrreq(wrreq),
    .data(data), .busy(busy), .pkt_seq(pkt_seq), .ovf_err(ovf_err)
  );

  always #5 wrclk = ~wrclk;

  typedef struct { logic [WIDTH-1:0] w; bit hdr; } exp_t;
  exp_t expq[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Packet-level reference model: phase 0 = between packets, 1 = payload, 2 = trailer.
  int               m_phase = 0;
  int               m_cnt   = 0;
  logic [7:0]       m_seq   = 8'd0;
  logic [WIDTH-1:0] m_sum   = '0;
  bit               m_ovf   = 1'b0;
  logic [WIDTH-1:0] exp_data = '0;
  int               n_pkts  = 0;
  logic [WIDTH-1:0] cur_data = 16'd1;
  bit               inc_mode = 1'b1;

  bit         hdr_chain = 1'b0;
  logic [7:0] last_hdr  = 8'd0;
  int         wraps     = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(logic [WIDTH-1:0] w, bit hdr);
    exp_t e;
    e.w = w;
    e.hdr = hdr;
    expq.push_back(e);
  endtask

  // One clock of stimulus; predicts what the coming rising edge must produce.
  task automatic step(bit e, bit v, bit full, logic [ADDR_W-1:0] usedw);
    @(negedge wrclk);
    en = e; s_valid = v; s_data = cur_data; wrfull = full; wrusedw = usedw;
    #1;
    chk("s_ready", s_ready, (m_phase == 1) && !full);
    case (m_phase)
      0: if (e && v && !full && (int'(usedw) + PKT + 2 <= CAP)) begin
           push({8'hA5, m_seq}, 1'b1);
           m_phase = 1; m_cnt = 0; m_sum = '0;
         end
      1: if (full) m_ovf = 1'b1;
         else if (v) begin
           push(cur_data, 1'b0);
           m_sum = m_sum + cur_data;
           m_cnt++;
           cur_data = inc_mode ? cur_data + 16'd1 : WIDTH'($urandom);
           if (m_cnt == BURST_LEN) begin
             if (CSUM) m_phase = 2;
             else begin m_phase = 0; m_seq = m_seq + 8'd1; n_pkts++; end
           end
         end
      default: if (full) m_ovf = 1'b1;
         else begin
           push(m_sum, 1'b0);
           m_phase = 0; m_seq = m_seq + 8'd1; n_pkts++;
         end
    endcase
  endtask

  task automatic finish_pkt();
    for (int i = 0; i < 50 && m_phase != 0; i++) step(1'b0, 1'b1, 1'b0, '0);
    chk("pkt_completes", m_phase, 0);
  endtask

  task automatic pulse_reset();
    @(negedge wrclk);
    en = 1'b0; s_valid = 1'b0; wrfull = 1'b0;
    #2 aclr = 1'b0;
    #1;
    chk("rst_wrreq", wrreq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pkt_seq", pkt_seq, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_data", data, 0);
    chk("rst_ovf_err", ovf_err, 0);
    m_phase = 0; m_seq = 8'd0; m_ovf = 1'b0; exp_data = '0;
    expq.delete();
    hdr_chain = 1'b0;
    #1 aclr = 1'b1;
  endtask

  // Monitor: every cycle, the write port must match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(posedge wrclk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("wrreq", wrreq, 1);
        chk("data", data, e.w);
        exp_data = e.w;
        if (e.hdr && wrreq) begin
          chk("hdr_sync", data[15:8], 8'hA5);
          if (hdr_chain) begin
            chk("hdr_seq_step", data[7:0], 8'(last_hdr + 8'd1));
            if (data[7:0] == 8'd0) wraps++;
          end
          last_hdr  = data[7:0];
          hdr_chain = 1'b1;
        end
      end else begin
        chk("wrreq_idle", wrreq, 0);
        chk("data_hold", data, exp_data);
      end
      chk("busy", busy, m_phase != 0);
      chk("pkt_seq", pkt_seq, m_seq);
      chk("ovf_err", ovf_err, m_ovf);
    end
  end

  // Stimulus.
  initial begin
    int start_pkts;
    repeat (2) @(negedge wrclk);
    chk("init_s_ready", s_ready, 0);
    chk("init_data", data, 0);
    #2 aclr = 1'b1;

    // Single packet, payload 1,2,3,4 gapless.
    inc_mode = 1'b1; cur_data = 16'd1;
    step(1'b1, 1'b1, 1'b0, '0);
    finish_pkt();
    step(1'b0, 1'b0, 1'b0, '0);
    chk("seq_after_first", m_seq, 1);

    // Room gating around the start threshold.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, ADDR_W'(LIMIT + 1));
    step(1'b1, 1'b1, 1'b0, ADDR_W'(LIMIT));
    finish_pkt();

    // Back-pressure: valid gaps, then wrfull for 3 cycles mid-payload.
    inc_mode = 1'b0;
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    finish_pkt();

    // Reset mid-packet after two payload words, then a fresh packet.
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    pulse_reset();
    step(1'b1, 1'b1, 1'b0, '0);
    finish_pkt();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 10) == 0,
           ($urandom % 4 == 0) ? ADDR_W'($urandom_range(0, CAP))
                               : ADDR_W'($urandom_range(0, LIMIT)));
    end
    finish_pkt();

    // Sequence wrap: gapless packets from a clean reset.
    pulse_reset();
    start_pkts = n_pkts;
    for (int i = 0; i < 4000 && (n_pkts - start_pkts) < 260; i++)
      step(1'b1, 1'b1, 1'b0, '0);
    finish_pkt();
    chk("wrap_pkt_count", (n_pkts - start_pkts) >= 260, 1);
    chk("seq_wrapped", wraps >= 1, 1);

    repeat (3) step(1'b0, 1'b0, 1'b0, '0);
    chk("scoreboard_empty", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
